// File: rtl/ram_bist_ctrl_if.sv
`timescale 1ns/1ps
// Single-port RAM bus between the BIST initiator (master) and the RAM (slave).
// Read data returns one cycle after the mem_re cycle; no backpressure on this bus.
interface ram_bist_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_we,
    output mem_re,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_we,
    input  mem_re,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/ram_bist_ctrl.sv
`timescale 1ns/1ps
// RAM self-test: write {~a,a}^PATTERN to all words, read back, compare 1 cycle later; done after 2*DEPTH+1 busy cycles.
// No backpressure (start only sampled in IDLE); RAM_BIST_INV_PASS_EN adds an inverted-data pass (4*DEPTH+1 busy cycles).
module ram_bist_ctrl #(
  parameter int                ADDR_W  = 4,
  parameter int                DATA_W  = 8,
  parameter logic [DATA_W-1:0] PATTERN = '0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  ram_bist_ctrl_if.master   mem,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [ADDR_W+1:0] err_count
);

  localparam logic [ADDR_W-1:0] LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
`ifdef RAM_BIST_INV_PASS_EN
    S_WRITE_INV,
    S_READ_INV,
`endif
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic              phase_act;
  logic              rd_phase;
  logic [DATA_W-1:0] rd_exp;
  logic              cmp_vld;
  logic [ADDR_W-1:0] cmp_addr;
  logic [DATA_W-1:0] cmp_exp;
  logic              mismatch;

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a, input logic inv);
    pat = {~a, a} ^ PATTERN ^ {DATA_W{inv}};
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    phase_act     = 1'b0;
    rd_phase      = 1'b0;
    rd_exp        = '0;
    mem.mem_we    = 1'b0;
    mem.mem_re    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        phase_act     = 1'b1;
        busy          = 1'b1;
        mem.mem_we    = 1'b1;
        mem.mem_addr  = cnt;
        mem.mem_wdata = pat(cnt, 1'b0);
        if (cnt == LAST) state_nxt = S_READ;
      end
      S_READ: begin
        phase_act    = 1'b1;
        busy         = 1'b1;
        rd_phase     = 1'b1;
        rd_exp       = pat(cnt, 1'b0);
        mem.mem_re   = 1'b1;
        mem.mem_addr = cnt;
`ifdef RAM_BIST_INV_PASS_EN
        if (cnt == LAST) state_nxt = S_WRITE_INV;
`else
        if (cnt == LAST) state_nxt = S_DRAIN;
`endif
      end
`ifdef RAM_BIST_INV_PASS_EN
      S_WRITE_INV: begin
        phase_act     = 1'b1;
        busy          = 1'b1;
        mem.mem_we    = 1'b1;
        mem.mem_addr  = cnt;
        mem.mem_wdata = pat(cnt, 1'b1);
        if (cnt == LAST) state_nxt = S_READ_INV;
      end
      S_READ_INV: begin
        phase_act    = 1'b1;
        busy         = 1'b1;
        rd_phase     = 1'b1;
        rd_exp       = pat(cnt, 1'b1);
        mem.mem_re   = 1'b1;
        mem.mem_addr = cnt;
        if (cnt == LAST) state_nxt = S_DRAIN;
      end
`endif
      S_DRAIN: begin
        busy      = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Counter runs freely through each phase and wraps LAST -> 0 exactly at the phase change.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)          cnt <= '0;
    else if (phase_act) cnt <= cnt + 1'b1;
    else                cnt <= '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmp_vld  <= 1'b0;
      cmp_addr <= '0;
      cmp_exp  <= '0;
    end else begin
      cmp_vld  <= rd_phase;
      cmp_addr <= cnt;
      cmp_exp  <= rd_exp;
    end
  end

  assign mismatch = cmp_vld && (mem.mem_rdata != cmp_exp);

  // The last compare lands in DRAIN, so pass folds in that cycle's mismatch to be valid with done.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pass      <= 1'b0;
      fail_addr <= '0;
      err_count <= '0;
    end else if (state == S_IDLE && start) begin
      pass      <= 1'b0;
      fail_addr <= '0;
      err_count <= '0;
    end else begin
      if (mismatch) begin
        err_count <= err_count + 1'b1;
        if (err_count == '0) fail_addr <= cmp_addr;
      end
      if (state == S_DRAIN) pass <= (err_count == '0) && !mismatch;
    end
  end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
`timescale 1ns/1ps
// Randomized bench for ram_bist_ctrl: two instances (PATTERN 00 and FF) against behavioural RAMs with fault injection.
module tb_ram_bist_ctrl;
  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
`ifdef RAM_BIST_INV_PASS_EN
  localparam int NPASS = 2;
`else
  localparam int NPASS = 1;
`endif
  localparam int BUSY_EXP = 2 * NPASS * DEPTH + 1;
  localparam int WIN      = BUSY_EXP + 6;

  logic          clk  = 1'b0;
  logic          rstn = 1'b0;
  logic [1:0]    start;
  logic [1:0]    busy, done, pass;
  logic [AW-1:0] fail_addr [2];
  logic [AW+1:0] err_count [2];
  logic [DW-1:0] mem0 [DEPTH];
  logic [DW-1:0] mem1 [DEPTH];
  logic [15:0]   cmask [2];
  logic [DW-1:0] cxor  [2];
  int            total = 0;
  int            bad   = 0;

  always #5 clk = ~clk;

  ram_bist_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
  ram_bist_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

  ram_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW), .PATTERN(8'h00)) dut0 (
    .clk(clk), .rstn(rstn), .start(start[0]), .mem(bus0.master),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .fail_addr(fail_addr[0]), .err_count(err_count[0])
  );

  ram_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW), .PATTERN(8'hFF)) dut1 (
    .clk(clk), .rstn(rstn), .start(start[1]), .mem(bus1.master),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .fail_addr(fail_addr[1]), .err_count(err_count[1])
  );

  // Registered-read RAMs; a set mask bit corrupts every read of that address by XOR.
  always @(posedge clk) begin
    if (bus0.mem_we) mem0[bus0.mem_addr] <= bus0.mem_wdata;
    if (bus0.mem_re) bus0.mem_rdata <= mem0[bus0.mem_addr] ^ (cmask[0][bus0.mem_addr] ? cxor[0] : 8'h00);
    if (bus1.mem_we) mem1[bus1.mem_addr] <= bus1.mem_wdata;
    if (bus1.mem_re) bus1.mem_rdata <= mem1[bus1.mem_addr] ^ (cmask[1][bus1.mem_addr] ? cxor[1] : 8'h00);
  end

  function automatic logic [DW-1:0] ref_data(input int a, input logic [DW-1:0] p, input int final_pass);
    logic [AW-1:0] a4;
    a4 = a[AW-1:0];
    ref_data = ({~a4, a4} ^ p) ^ ((final_pass == 2) ? 8'hFF : 8'h00);
  endfunction

  function automatic logic [26:0] outs(input int sel);
    if (sel == 0)
      outs = {busy[0], done[0], pass[0], fail_addr[0], err_count[0],
              bus0.mem_we, bus0.mem_re, bus0.mem_addr, bus0.mem_wdata};
    else
      outs = {busy[1], done[1], pass[1], fail_addr[1], err_count[1],
              bus1.mem_we, bus1.mem_re, bus1.mem_addr, bus1.mem_wdata};
  endfunction

  // Pulses start on one instance and observes a fixed window; returns observations only.
  task automatic do_run(input int sel, input int extra_at, output int busy_cyc,
                        output int done_lat, output int done_cnt, output int proto_bad);
    logic we, re;
    logic [26:0] o;
    busy_cyc = 0; done_lat = -1; done_cnt = 0; proto_bad = 0;
    @(negedge clk) start[sel] = 1'b1;
    @(negedge clk) start[sel] = 1'b0;
    for (int n = 1; n <= WIN; n++) begin
      o  = outs(sel);
      we = o[13];
      re = o[12];
      if (o[26]) busy_cyc++;
      if (o[25]) begin
        done_cnt++;
        if (done_lat < 0) done_lat = n;
      end
      if (we && re) proto_bad++;
      if (!we && !re && o[11:0] != 12'h000) proto_bad++;
      if (n == extra_at) start[sel] = 1'b1;
      else if (n == extra_at + 1) start[sel] = 1'b0;
      @(negedge clk);
    end
    start[sel] = 1'b0;
  endtask

  task automatic test_reset;
    logic [26:0] o;
    rstn = 1'b0;
    for (int c = 0; c < 8; c++) begin
      start = 2'($urandom_range(0, 3));
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        o = outs(s);
        total++;
        if (o !== 27'd0) begin
          bad++;
          $display("FAIL reset_outs dut%0d cycle %0d got=%h want=0", s, c, o);
        end
      end
    end
    start = 2'b00;
    @(negedge clk) rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_good_run;
    int bc, dl, dc, pb;
    do_run(0, -10, bc, dl, dc, pb);
    total++; if (bc !== BUSY_EXP)   begin bad++; $display("FAIL good_busy got=%0d want=%0d", bc, BUSY_EXP); end
    total++; if (dl !== BUSY_EXP+1) begin bad++; $display("FAIL good_done_lat got=%0d want=%0d", dl, BUSY_EXP+1); end
    total++; if (dc !== 1)          begin bad++; $display("FAIL good_done_cnt got=%0d want=1", dc); end
    total++; if (pb !== 0)          begin bad++; $display("FAIL good_protocol got=%0d want=0", pb); end
    total++; if (pass[0] !== 1'b1)  begin bad++; $display("FAIL good_pass got=%b want=1", pass[0]); end
    total++; if (err_count[0] !== 6'd0) begin bad++; $display("FAIL good_err got=%0d want=0", err_count[0]); end
    total++; if (fail_addr[0] !== 4'd0) begin bad++; $display("FAIL good_fail_addr got=%0d want=0", fail_addr[0]); end
    for (int a = 0; a < DEPTH; a++) begin
      total++;
      if (mem0[a] !== ref_data(a, 8'h00, NPASS)) begin
        bad++;
        $display("FAIL good_ram[%0d] got=%h want=%h", a, mem0[a], ref_data(a, 8'h00, NPASS));
      end
    end
  endtask

  task automatic test_corrupt_addr5;
    int bc, dl, dc, pb;
    cmask[0] = 16'h0020;
    cxor[0]  = 8'hA5;
    do_run(0, -10, bc, dl, dc, pb);
    cmask[0] = 16'h0000;
    total++; if (pass[0] !== 1'b0) begin bad++; $display("FAIL corrupt_pass got=%b want=0", pass[0]); end
    total++; if (err_count[0] !== 6'(NPASS)) begin bad++; $display("FAIL corrupt_err got=%0d want=%0d", err_count[0], NPASS); end
    total++; if (fail_addr[0] !== 4'd5) begin bad++; $display("FAIL corrupt_fail_addr got=%0d want=5", fail_addr[0]); end
  endtask

  task automatic test_start_ignored;
    int bc, dl, dc, pb;
    do_run(0, 3, bc, dl, dc, pb);
    total++; if (dl !== BUSY_EXP+1) begin bad++; $display("FAIL ignore_done_lat got=%0d want=%0d", dl, BUSY_EXP+1); end
    total++; if (dc !== 1)          begin bad++; $display("FAIL ignore_done_cnt got=%0d want=1", dc); end
    total++; if (bc !== BUSY_EXP)   begin bad++; $display("FAIL ignore_busy got=%0d want=%0d", bc, BUSY_EXP); end
    total++; if (pass[0] !== 1'b1)  begin bad++; $display("FAIL ignore_pass got=%b want=1", pass[0]); end
  endtask

  task automatic test_reset_mid_run;
    int bc, dl, dc, pb;
    logic [26:0] o;
    @(negedge clk) start[0] = 1'b1;
    @(negedge clk) start[0] = 1'b0;
    repeat (DEPTH + 7) @(negedge clk);
    total++;
    if (bus0.mem_re !== 1'b1 || bus0.mem_addr !== 4'd7) begin
      bad++;
      $display("FAIL midrst_read7 got re=%b addr=%0d want re=1 addr=7", bus0.mem_re, bus0.mem_addr);
    end
    rstn = 1'b0;
    #1;
    o = outs(0);
    total++; if (o !== 27'd0) begin bad++; $display("FAIL midrst_outs got=%h want=0", o); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (done[0] !== 1'b0 || busy[0] !== 1'b0) begin
        bad++; $display("FAIL midrst_hold got done=%b busy=%b want 0 0", done[0], busy[0]);
      end
    end
    rstn = 1'b1;
    @(negedge clk);
    do_run(0, -10, bc, dl, dc, pb);
    total++; if (pass[0] !== 1'b1)  begin bad++; $display("FAIL midrst_rerun_pass got=%b want=1", pass[0]); end
    total++; if (dl !== BUSY_EXP+1) begin bad++; $display("FAIL midrst_rerun_lat got=%0d want=%0d", dl, BUSY_EXP+1); end
  endtask

  task automatic test_pattern_ff;
    int bc, dl, dc, pb;
    do_run(1, -10, bc, dl, dc, pb);
    total++; if (mem1[0] !== (8'h0F ^ ((NPASS == 2) ? 8'hFF : 8'h00))) begin
      bad++; $display("FAIL patff_ram0 got=%h", mem1[0]); end
    total++; if (mem1[5] !== (8'h5A ^ ((NPASS == 2) ? 8'hFF : 8'h00))) begin
      bad++; $display("FAIL patff_ram5 got=%h", mem1[5]); end
    total++; if (pass[1] !== 1'b1) begin bad++; $display("FAIL patff_pass got=%b want=1", pass[1]); end
    total++; if (bc !== BUSY_EXP)  begin bad++; $display("FAIL patff_busy got=%0d want=%0d", bc, BUSY_EXP); end
    total++; if (pb !== 0)         begin bad++; $display("FAIL patff_protocol got=%0d want=0", pb); end
  endtask

  task automatic test_random;
    int bc, dl, dc, pb, sel, exp_err, exp_fa;
    logic [15:0] m;
    for (int it = 0; it < 8; it++) begin
      sel = $urandom_range(0, 1);
      m   = (it % 3 == 0) ? 16'h0000 : 16'($urandom);
      cmask[sel] = m;
      cxor[sel]  = 8'($urandom_range(1, 255));
      exp_err = $countones(m) * NPASS;
      exp_fa  = 0;
      for (int a = DEPTH - 1; a >= 0; a--) if (m[a]) exp_fa = a;
      do_run(sel, -10, bc, dl, dc, pb);
      cmask[sel] = 16'h0000;
      total++; if (err_count[sel] !== 6'(exp_err)) begin
        bad++; $display("FAIL rand%0d_err dut%0d got=%0d want=%0d", it, sel, err_count[sel], exp_err); end
      total++; if (fail_addr[sel] !== 4'(exp_fa)) begin
        bad++; $display("FAIL rand%0d_fail_addr dut%0d got=%0d want=%0d", it, sel, fail_addr[sel], exp_fa); end
      total++; if (pass[sel] !== (m == 16'h0000)) begin
        bad++; $display("FAIL rand%0d_pass dut%0d got=%b want=%b", it, sel, pass[sel], (m == 16'h0000)); end
      total++; if (dl !== BUSY_EXP+1 || pb !== 0) begin
        bad++; $display("FAIL rand%0d_timing dut%0d got lat=%0d proto=%0d want lat=%0d proto=0", it, sel, dl, pb, BUSY_EXP+1); end
    end
  endtask

  initial begin
    start    = 2'b00;
    cmask[0] = 16'h0000;
    cmask[1] = 16'h0000;
    cxor[0]  = 8'h00;
    cxor[1]  = 8'h00;
    test_reset;
    test_good_run;
    test_corrupt_addr5;
    test_start_ignored;
    test_reset_mid_run;
    test_pattern_ff;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
